// File: rtl/axi_phased_delay_gen_if.sv
// AXI4-Lite slave bundle for the phased delay generator register file.
// Signal names mirror the PS interconnect port names so board wiring is one-to-one.
interface axi_phased_delay_gen_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_phased_delay_gen.sv
// Multi-channel phased pulse generator: one shared period counter, per-channel delays,
// double-buffered delay/width with commit on a period boundary, and finite burst mode.
module axi_phased_delay_gen #(
  parameter int NUM_CH   = 16,
  parameter int DELAY_W  = 16,
  parameter int PERIOD_W = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi_phased_delay_gen_if.slave s_axi,
  output logic [NUM_CH-1:0]     pulse_out,
  output logic                  frame_sync,
  output logic                  running,
  output logic                  dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam int CMP_W = ((DELAY_W > PERIOD_W) ? DELAY_W : PERIOD_W) + 1;
  localparam int WA_W  = ADDR_W - 2;

  // Handshake: a write is accepted on the single cycle AWREADY/WREADY are high;
  // BVALID/RVALID then hold until BREADY/RREADY, and only one of each is in flight.
  logic              awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]       rdata_q, rd_data;
  logic              aw_go, ar_go, wr_en;
  logic [WA_W-1:0]   wr_word, rd_word;
  logic              wr_ok, rd_ok, wr_ctrl, wr_period, wr_burst, wr_width;

  logic                enable_q, mode_q, commit_pending_q;
  logic [PERIOD_W-1:0] period_q, cnt_q, cnt_d;
  logic [15:0]         burst_cnt_q, remaining_q, remaining_d;
  logic [DELAY_W-1:0]  width_sh_q, width_act_q;
  logic [DELAY_W-1:0]  delay_sh_q  [NUM_CH];
  logic [DELAY_W-1:0]  delay_act_q [NUM_CH];
  state_e              state_q, state_d;
  logic                hw_clear, do_copy;
  logic [NUM_CH-1:0]   pulse_q, pulse_d;
  logic                frame_sync_q, frame_sync_d;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic in_window(input logic [PERIOD_W-1:0] c, input logic [DELAY_W-1:0] d,
                                     input logic [DELAY_W-1:0] w);
    logic [CMP_W-1:0] cx, dx, ex;
    cx = CMP_W'(c);
    dx = CMP_W'(d);
    ex = dx + CMP_W'(w);
    return (cx >= dx) && (cx < ex);
  endfunction

  assign aw_go   = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q && !awready_q;
  assign ar_go   = s_axi.S_AXI_ARVALID && !rvalid_q && !arready_q;
  assign wr_en   = awready_q;
  assign wr_word = s_axi.S_AXI_AWADDR[ADDR_W-1:2];
  assign rd_word = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
  // Unaligned addresses are treated as unmapped.
  assign wr_ok     = wr_en && (s_axi.S_AXI_AWADDR[1:0] == 2'b00);
  assign rd_ok     = (s_axi.S_AXI_ARADDR[1:0] == 2'b00);
  assign wr_ctrl   = wr_ok && (wr_word == WA_W'(0));
  assign wr_period = wr_ok && (wr_word == WA_W'(1));
  assign wr_burst  = wr_ok && (wr_word == WA_W'(2));
  assign wr_width  = wr_ok && (wr_word == WA_W'(4));

  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      case (rd_word)
        WA_W'(0): rd_data = {29'd0, commit_pending_q, mode_q, enable_q};
        WA_W'(1): rd_data = 32'(period_q);
        WA_W'(2): rd_data = 32'(burst_cnt_q);
        WA_W'(3): rd_data = {remaining_q, 14'd0, commit_pending_q, state_q == S_RUN};
        WA_W'(4): rd_data = 32'(width_sh_q);
        default:  rd_data = '0;
      endcase
      for (int ch = 0; ch < NUM_CH; ch++)
        if (rd_word == WA_W'(8 + ch)) rd_data = 32'(delay_sh_q[ch]);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    hw_clear    = 1'b0;
    do_copy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        do_copy = commit_pending_q;
        if (enable_q) begin
          if (mode_q && (burst_cnt_q == 16'd0)) begin
            hw_clear = 1'b1;
          end else begin
            state_d     = S_RUN;
            remaining_d = mode_q ? burst_cnt_q : 16'd0;
          end
        end
      end
      S_RUN: begin
        if (!enable_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_q) begin
          cnt_d   = '0;
          do_copy = commit_pending_q;
          if (mode_q) begin
            remaining_d = (remaining_q != 16'd0) ? remaining_q - 16'd1 : 16'd0;
            if (remaining_q <= 16'd1) begin
              hw_clear = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    frame_sync_d = (state_q == S_RUN) && enable_q && (cnt_q == '0);
    pulse_d      = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      pulse_d[ch] = (state_q == S_RUN) && enable_q && in_window(cnt_q, delay_act_q[ch], width_act_q);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q        <= 1'b0;
      bvalid_q         <= 1'b0;
      arready_q        <= 1'b0;
      rvalid_q         <= 1'b0;
      rdata_q          <= '0;
      enable_q         <= 1'b0;
      mode_q           <= 1'b0;
      commit_pending_q <= 1'b0;
      period_q         <= '0;
      burst_cnt_q      <= '0;
      width_sh_q       <= '0;
      width_act_q      <= '0;
      pulse_q          <= '0;
      frame_sync_q     <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        delay_sh_q[ch]  <= '0;
        delay_act_q[ch] <= '0;
      end
    end else begin
      awready_q <= aw_go;
      if (awready_q)                bvalid_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY)  bvalid_q <= 1'b0;
      arready_q <= ar_go;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      pulse_q      <= pulse_d;
      frame_sync_q <= frame_sync_d;

      // Copy reads the registered shadow, so a same-cycle shadow write lands after it.
      if (do_copy) begin
        width_act_q <= width_sh_q;
        for (int ch = 0; ch < NUM_CH; ch++) delay_act_q[ch] <= delay_sh_q[ch];
      end

      // Software CTRL writes take priority over the hardware burst-end clear.
      if (wr_ctrl && s_axi.S_AXI_WSTRB[0]) begin
        enable_q <= s_axi.S_AXI_WDATA[0];
        mode_q   <= s_axi.S_AXI_WDATA[1];
      end else if (hw_clear) begin
        enable_q <= 1'b0;
      end
      if (wr_ctrl && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[2]) commit_pending_q <= 1'b1;
      else if (do_copy)                                            commit_pending_q <= 1'b0;

      if (wr_period)
        period_q <= PERIOD_W'(merge_strb(32'(period_q), s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB));
      if (wr_burst)
        burst_cnt_q <= 16'(merge_strb(32'(burst_cnt_q), s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB));
      if (wr_width)
        width_sh_q <= DELAY_W'(merge_strb(32'(width_sh_q), s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB));
      for (int ch = 0; ch < NUM_CH; ch++)
        if (wr_ok && (wr_word == WA_W'(8 + ch)))
          delay_sh_q[ch] <= DELAY_W'(merge_strb(32'(delay_sh_q[ch]), s_axi.S_AXI_WDATA,
                                                s_axi.S_AXI_WSTRB));
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign pulse_out   = pulse_q;
  assign frame_sync  = frame_sync_q;
  assign running     = (state_q == S_RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_phased_delay_gen.sv
// Directed bench for axi_phased_delay_gen: register map, pulse timing, commit,
// burst mode, edge values, AXI back-pressure and mid-run reset.
module tb_axi_phased_delay_gen;
  localparam int NUM_CH   = 16;
  localparam int DELAY_W  = 16;
  localparam int PERIOD_W = 16;
  localparam int ADDR_W   = 8;
  localparam int TMO      = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_phased_delay_gen_if #(.ADDR_W(ADDR_W)) bus ();
  logic [NUM_CH-1:0] pulse_out;
  logic              frame_sync, running, dbg_state;

  axi_phased_delay_gen #(
    .NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .PERIOD_W(PERIOD_W), .ADDR_W(ADDR_W)
  ) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus.slave),
    .pulse_out(pulse_out), .frame_sync(frame_sync), .running(running), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          m_first[NUM_CH];
  int          m_len[NUM_CH];
  int          m_fs_extra;
  logic        m_fs_next;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb = 4'hF);
    int n;
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < TMO);
    if (!bus.S_AXI_AWREADY) begin
      check_eq("aw_timeout", 32'd0, 32'd1);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_BVALID && n < TMO) begin @(negedge clk); n++; end
    if (!bus.S_AXI_BVALID) check_eq("b_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
    int n;
    data = '0;
    @(posedge clk); #1;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < TMO);
    if (!bus.S_AXI_ARREADY) begin
      check_eq("ar_timeout", 32'd0, 32'd1);
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_RVALID && n < TMO);
    if (!bus.S_AXI_RVALID) check_eq("r_timeout", 32'd0, 32'd1);
    data = bus.S_AXI_RDATA;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_sync && n < 500);
    if (!frame_sync) check_eq("frame_timeout", 32'd0, 32'd1);
  endtask

  // Samples one whole period starting at a frame_sync; offsets are cycles after it.
  task automatic measure(input int plen);
    wait_frame();
    for (int ch = 0; ch < NUM_CH; ch++) begin m_first[ch] = -1; m_len[ch] = 0; end
    m_fs_extra = 0;
    for (int off = 0; off < plen; off++) begin
      if (off > 0 && frame_sync) m_fs_extra++;
      for (int ch = 0; ch < NUM_CH; ch++)
        if (pulse_out[ch]) begin
          if (m_first[ch] < 0) m_first[ch] = off;
          m_len[ch]++;
        end
      @(negedge clk);
    end
    m_fs_next = frame_sync;
  endtask

  task automatic count_frames(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (frame_sync) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  rd_addrs [10];
    logic [31:0] d, r0;
    int          fs;
    logic        stable;
    int          n;

    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_pulse", 32'(pulse_out), 32'd0);
    check_eq("rst_frame", 32'(frame_sync), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check_eq("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);

    rd_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h5C, 8'h14, 8'hFC};
    for (int i = 0; i < 10; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 10; i++) begin
      axi_read(rd_addrs[i], d);
      check_eq($sformatf("rst_reg_%0h", rd_addrs[i]), d, exp_q.pop_front());
    end

    // Continuous mode, period 100
    axi_write(8'h04, 32'd99);
    axi_write(8'h10, 32'd5);
    axi_write(8'h20, 32'd0);
    axi_write(8'h24, 32'd10);
    axi_write(8'h58, 32'd97);
    axi_write(8'h5C, 32'd95);
    axi_write(8'h00, 32'h5);
    measure(100);
    check_eq("cont_ch0_first", m_first[0], 0);
    check_eq("cont_ch0_len", m_len[0], 5);
    check_eq("cont_ch1_first", m_first[1], 10);
    check_eq("cont_ch1_len", m_len[1], 5);
    check_eq("cont_ch15_first", m_first[15], 95);
    check_eq("cont_ch15_len", m_len[15], 5);
    check_eq("cont_ch14_trunc", m_len[14], 3);
    check_eq("cont_fs_extra", m_fs_extra, 0);
    check_eq("cont_fs_period", 32'(m_fs_next), 32'd1);

    // Shadow write without commit leaves timing alone
    axi_write(8'h24, 32'd40);
    measure(100);
    check_eq("nocommit_ch1_first", m_first[1], 10);
    read_check("shadow_readback", 8'h24, 32'd40);

    repeat (10) @(negedge clk);
    axi_write(8'h00, 32'h5);
    read_check("commit_ctrl_pending", 8'h00, 32'h5);
    read_check("commit_status_pending", 8'h0C, 32'h3);
    measure(100);
    check_eq("commit_ch1_first", m_first[1], 40);
    check_eq("commit_ch1_len", m_len[1], 5);
    read_check("commit_ctrl_done", 8'h00, 32'h1);
    read_check("commit_status_done", 8'h0C, 32'h1);

    axi_write(8'h00, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("disable_running", 32'(running), 32'd0);
    check_eq("disable_pulse", 32'(pulse_out), 32'd0);

    // Burst mode
    axi_write(8'h04, 32'd19);
    axi_write(8'h08, 32'd3);
    axi_write(8'h00, 32'h3);
    count_frames(150, fs);
    check_eq("burst3_frames", fs, 3);
    read_check("burst3_ctrl", 8'h00, 32'h2);
    read_check("burst3_status", 8'h0C, 32'h0);
    check_eq("burst3_running", 32'(running), 32'd0);

    axi_write(8'h08, 32'd0);
    axi_write(8'h00, 32'h3);
    count_frames(40, fs);
    check_eq("burst0_frames", fs, 0);
    read_check("burst0_ctrl", 8'h00, 32'h2);

    // Edge values at period 20
    axi_write(8'h00, 32'h0);
    axi_write(8'h10, 32'd5);
    axi_write(8'h20, 32'd20);
    axi_write(8'h24, 32'd19);
    axi_write(8'h28, 32'd0);
    axi_write(8'h00, 32'h5);
    measure(20);
    check_eq("edge_past_period_len", m_len[0], 0);
    check_eq("edge_at_period_first", m_first[1], 19);
    check_eq("edge_at_period_len", m_len[1], 1);
    check_eq("edge_ch2_len", m_len[2], 5);

    axi_write(8'h00, 32'h0);
    axi_write(8'h10, 32'd0);
    axi_write(8'h00, 32'h5);
    measure(20);
    check_eq("width0_ch2_len", m_len[2], 0);
    check_eq("width0_ch1_len", m_len[1], 0);
    axi_write(8'h00, 32'h0);

    axi_write(8'h2C, 32'h1234);
    axi_write(8'h2C, 32'hABCD, 4'b0001);
    read_check("wstrb_byte0", 8'h2C, 32'h12CD);

    // Write back-pressure: BVALID held, no second AWREADY
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 8'h10; bus.S_AXI_WDATA = 32'd7; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < TMO);
    check_eq("bp_aw_seen", 32'(bus.S_AXI_AWREADY), 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 8'h30; bus.S_AXI_WDATA = 32'h55;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.S_AXI_BVALID || bus.S_AXI_AWREADY) stable = 1'b0;
    end
    check_eq("bp_b_hold", 32'(stable), 32'd1);
    @(posedge clk); #1 bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1 bus.S_AXI_BREADY = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < TMO);
    check_eq("bp_aw2_seen", 32'(bus.S_AXI_AWREADY), 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1 bus.S_AXI_BREADY = 1'b0;
    read_check("bp_wr1", 8'h30, 32'h55);

    // Read back-pressure: RVALID/RDATA held
    @(posedge clk); #1;
    bus.S_AXI_ARADDR = 8'h10; bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < TMO);
    @(posedge clk); #1 bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    r0 = bus.S_AXI_RDATA;
    stable = bus.S_AXI_RVALID;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== r0) stable = 1'b0;
    end
    check_eq("bp_r_hold", 32'(stable), 32'd1);
    check_eq("bp_r_data", r0, 32'd7);
    @(posedge clk); #1 bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1 bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check_eq("bp_r_cleared", 32'(bus.S_AXI_RVALID), 32'd0);

    // Reset while running, mid-pulse
    axi_write(8'h04, 32'd99);
    axi_write(8'h10, 32'd5);
    axi_write(8'h20, 32'd0);
    axi_write(8'h00, 32'h5);
    wait_frame();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_pulse", 32'(pulse_out), 32'd0);
    check_eq("mid_rst_running", 32'(running), 32'd0);
    check_eq("mid_rst_frame", 32'(frame_sync), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    read_check("mid_rst_ctrl", 8'h00, 32'h0);
    read_check("mid_rst_period", 8'h04, 32'h0);
    read_check("mid_rst_width", 8'h10, 32'h0);
    read_check("mid_rst_delay0", 8'h20, 32'h0);
    count_frames(30, fs);
    check_eq("mid_rst_no_frames", fs, 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_phased_delay_gen.md
Name: axi_phased_delay_gen

Overview:
- Parametrised multi-channel successor to the AXI delay generator. Takes an AXI4-Lite register interface and drives NUM_CH transducer pulse outputs.
- All channels share one period counter. Each channel fires a pulse of common width at its own programmable delay within the period.
- Adds double-buffered delay and width registers with atomic commit on a period boundary, plus a finite burst mode.
- Sits between the PS AXI interconnect and the transducer driver I/O.

Parameters:
NUM_CH, 16, number of pulse channels (1..56)
DELAY_W, 16, width of per-channel delay and pulse width fields, in clocks
PERIOD_W, 16, width of period and counter fields
ADDR_W, 8, AXI-Lite address width; must cover 0x20+4*(NUM_CH-1)

Ports:
ACLK  in  1  system clock
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always OKAY (2'b00)
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always OKAY
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake
pulse_out  out  NUM_CH  per-channel drive pulses, registered
frame_sync  out  1  one-cycle strobe at each period start, registered
running  out  1  period counter active

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: [0] enable, [1] mode (0 = continuous, 1 = burst), [2] commit (write-1, reads 1 while pending).
  - 0x04 PERIOD: period length minus 1.
  - 0x08 BURST_CNT: number of periods per burst.
  - 0x0C STATUS, read-only: [0] running, [1] commit_pending, [31:16] bursts remaining.
  - 0x10 WIDTH: shadow pulse width.
  - 0x20+4*ch: shadow DELAY[ch].
  - Unmapped reads return 0; unmapped writes are ignored; both respond OKAY.
- WSTRB is honoured per byte on all writable registers.
- AXI write: AWREADY and WREADY pulse high together for one cycle when AWVALID & WVALID & !BVALID. BVALID asserts the next cycle and holds until BREADY. One write outstanding at a time.
- AXI read: ARREADY pulses one cycle when ARVALID & !RVALID. RVALID asserts the next cycle and holds until RREADY. RDATA is stable while RVALID is high.
- Reset: every register, counter, shadow and active copy is 0. pulse_out, frame_sync, running, AWREADY, WREADY, BVALID, ARREADY and RVALID are all 0.
- Counter states: IDLE and RUN.
  - IDLE→RUN the cycle after enable becomes 1; cnt starts at 0.
  - In RUN, cnt increments and wraps PERIOD→0.
  - enable=0 → IDLE next cycle; cnt=0; outputs low next cycle; active registers retained.
- Outputs are registered, with 1 cycle latency from cnt:
  - frame_sync=1 in the cycle after cnt==0.
  - pulse_out[ch]=1 in the cycle after cnt satisfies DELAY_act[ch] <= cnt < DELAY_act[ch]+WIDTH_act.
  - The comparison uses DELAY_W+1 bits; there is no wrap. A pulse that runs past PERIOD is truncated at the period end.
  - A DELAY greater than PERIOD never fires; WIDTH=0 never fires.
  - Consequence: the pulse_out[ch] rising edge is DELAY[ch] cycles after the frame_sync rising edge.
- Commit:
  - A write with commit=1 sets commit_pending.
  - In IDLE, shadow copies to active on the next cycle.
  - In RUN, shadow copies to active in the cycle cnt==PERIOD, so the new values apply from the next cnt==0.
  - commit_pending clears when the copy happens.
  - A shadow write in the same cycle as the copy is not included; the copy takes the pre-write shadow.
  - PERIOD itself is not shadowed and takes effect immediately. If PERIOD is lowered below cnt, cnt runs to the 2^PERIOD_W wrap; software must disable before changing PERIOD.
- Burst mode:
  - On IDLE→RUN, remaining is loaded from BURST_CNT.
  - remaining decrements at each cnt==PERIOD. When it reaches 0, hardware clears enable and returns to IDLE.
  - BURST_CNT=0: enable self-clears the cycle after it is set, with no frame_sync.
  - A software write to CTRL in the same cycle as the hardware clear wins.
- Continuous mode: runs until disabled; remaining reads 0.
- ARESET mid-operation: everything returns to reset state in the following cycle, including any pending AXI response, which is dropped.

Test Plan:
- Reset, read all registers → every read returns 0x0. pulse_out=0, frame_sync=0, running=0.
- PERIOD=99, WIDTH=5, DELAY[0]=0, DELAY[1]=10, DELAY[NUM_CH-1]=95, commit, enable continuous:
  - frame_sync every 100 cycles.
  - pulse_out[1] high cycles 10..14 after frame_sync.
  - last channel high 95..99 then truncated (5 cycles).
- While running with DELAY[1]=10, write DELAY[1]=40 without commit → timing unchanged. Then commit mid-period → change appears exactly at the next frame_sync, and commit_pending reads 1 until the boundary.
- Burst mode, BURST_CNT=3, PERIOD=19:
  - exactly 3 frame_sync pulses.
  - CTRL[0] then reads 0, running=0, STATUS[31:16]=0.
  - Repeat with BURST_CNT=0 → no frame_sync.
- Edge values: DELAY=PERIOD+1 → no pulse; WIDTH=0 → no pulse; WSTRB=4'b0001 on DELAY → only bits [7:0] change.
- AXI handshakes: hold BREADY/RREADY low for 10 cycles → BVALID/RVALID and RDATA held stable; no second AWREADY until BVALID clears.
- ARESET during RUN → outputs 0 the next cycle, registers read 0.
